// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd parity).
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_tx_framer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tx_q;
  logic                   bit_end_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign bit_end_d = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // bit_q counts data bits in DATA and stop bits in STOP; it is 0 on entry to both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
      bit_q <= '0;
      if (valid) begin
        shift_q <= in;
        tx_q    <= 1'b0;
        state_q <= S_START;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^in) ^ (PARITY_ODD != 0);
`endif
      end
    end else if (!bit_end_d) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_START: begin
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
        end
        S_DATA: begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            state_q <= S_PARITY;
            tx_q    <= par_q;
`else
            state_q <= S_STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign tx    = tx_q;

endmodule
